// File: rtl/tof_fb_write_arb_pkg.sv
// ============================================================================
// Module   : tof_fb_pkg
// Purpose  : Shared framebuffer geometry, arbiter state encoding, pixel type.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tof_fb_pkg;

    localparam int FB_X_W    = 8;
    localparam int FB_Y_W    = 8;
    localparam int FB_ADDR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_PLOT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [FB_Y_W-1:0] y;
        logic [FB_X_W-1:0] x;
    } fb_coord_t;

    // Framebuffer addresses are row-major: {y, x}.
    function automatic logic [FB_ADDR_W-1:0] coord_addr(input fb_coord_t c);
        return {c.y, c.x};
    endfunction

endpackage

`default_nettype wire

// File: rtl/tof_fb_write_arb_if.sv
// ============================================================================
// Module   : tof_fb_write_arb_if
// Purpose  : Clear-engine, plot-request and framebuffer write-port bundle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface tof_fb_write_arb_if
    import tof_fb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 16
);
    logic                          clr_busy;
    logic                          clr_wr_en;
    logic [FB_X_W-1:0]             clr_wr_x;
    logic [FB_Y_W-1:0]             clr_wr_y;
    logic                          clr_wr_data;
    logic                          plot_valid;
    logic                          plot_ready;
    logic [FB_X_W-1:0]             plot_x;
    logic [FB_Y_W-1:0]             plot_y;
    logic                          fb_we;
    logic [ADDR_W-1:0]             fb_addr;
    logic                          fb_din;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic [15:0]                   pix_count;

    modport master (
        output clr_busy, clr_wr_en, clr_wr_x, clr_wr_y, clr_wr_data,
        output plot_valid, plot_x, plot_y,
        input  plot_ready, fb_we, fb_addr, fb_din, fifo_level, pix_count
    );

    modport slave (
        input  clr_busy, clr_wr_en, clr_wr_x, clr_wr_y, clr_wr_data,
        input  plot_valid, plot_x, plot_y,
        output plot_ready, fb_we, fb_addr, fb_din, fifo_level, pix_count
    );

endinterface

`default_nettype wire

// File: rtl/tof_sync_fifo.sv
// ============================================================================
// Module   : tof_sync_fifo
// Purpose  : Single-clock FIFO with registered space/empty flags and level.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tof_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk_i,
    input  wire logic                     rst_n_i,
    input  wire logic                     push_i,
    input  wire logic                     pop_i,
    input  wire logic [WIDTH-1:0]         din_i,
    output logic      [WIDTH-1:0]         dout_o,
    output logic                          space_o,
    output logic                          empty_o,
    output logic      [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             space_q;
    logic             empty_q;
    logic             w_push;
    logic             w_pop;

    assign w_push = push_i & space_q;
    assign w_pop  = pop_i & ~empty_q;

    always_comb begin
        level_d = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // space_q resets low so the producer sees not-ready until the first clock.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            space_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            space_q <= (level_d != LVL_W'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign space_o = space_q;
    assign empty_o = empty_q;
    assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/tof_fb_write_arb.sv
// ============================================================================
// Module   : tof_fb_write_arb
// Purpose  : Arbitrates clear-engine writes (absolute priority) against queued
//            plot pixels onto one framebuffer write port.
//            Optional pixel statistics: define TOF_FB_ARB_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tof_fb_write_arb
    import tof_fb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic           clk_sys,
    input  wire logic           rst_sys_n,
    tof_fb_write_arb_if.slave   bus
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    arb_state_e         state_q;
    arb_state_e         state_d;
    fb_coord_t          w_plot_coord;
    fb_coord_t          w_fifo_dout;
    logic               w_fifo_space;
    logic               w_fifo_empty;
    logic [LVL_W-1:0]   w_fifo_level;
    logic               w_push;
    logic               w_pop;
    logic               w_last;
    logic               fb_we_q,   fb_we_d;
    logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
    logic               fb_din_q,  fb_din_d;

    assign w_plot_coord = '{y: bus.plot_y, x: bus.plot_x};
    assign w_push       = bus.plot_valid & w_fifo_space;
    // Any clear activity in the current cycle blocks the pop, keeping the port free.
    assign w_pop        = (state_q == S_PLOT) & ~w_fifo_empty & ~bus.clr_busy & ~bus.clr_wr_en;
    assign w_last       = w_pop & ~w_push & (w_fifo_level == LVL_W'(1));

    tof_sync_fifo #(
        .WIDTH (FB_ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_sys),
        .rst_n_i (rst_sys_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_plot_coord),
        .dout_o  (w_fifo_dout),
        .space_o (w_fifo_space),
        .empty_o (w_fifo_empty),
        .level_o (w_fifo_level)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.clr_busy)       state_d = S_CLEAR;
                else if (!w_fifo_empty) state_d = S_PLOT;
            end
            S_CLEAR: begin
                if (bus.clr_busy)                           state_d = S_CLEAR;
                else if (!bus.clr_wr_en && !w_fifo_empty)   state_d = S_PLOT;
                else                                        state_d = S_IDLE;
            end
            S_PLOT: begin
                if (bus.clr_busy)                   state_d = S_CLEAR;
                else if (w_last || w_fifo_empty)    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fb_we_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_din_d  = fb_din_q;
        if (bus.clr_wr_en) begin
            fb_we_d   = 1'b1;
            fb_addr_d = ADDR_W'({bus.clr_wr_y, bus.clr_wr_x});
            fb_din_d  = bus.clr_wr_data;
        end else if (w_pop) begin
            fb_we_d   = 1'b1;
            fb_addr_d = ADDR_W'(coord_addr(w_fifo_dout));
            fb_din_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q   <= S_IDLE;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_din_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_din_q  <= fb_din_d;
        end
    end

    assign bus.plot_ready = w_fifo_space;
    assign bus.fifo_level = w_fifo_level;
    assign bus.fb_we      = fb_we_q;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.fb_din     = fb_din_q;

`ifdef TOF_FB_ARB_STATS_EN
    logic [15:0] pix_count_q;
    logic        clr_busy_q;

    // Counter restarts on the rising edge of clr_busy, i.e. at each clear start.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            pix_count_q <= '0;
            clr_busy_q  <= 1'b0;
        end else begin
            clr_busy_q <= bus.clr_busy;
            if (bus.clr_busy && !clr_busy_q)
                pix_count_q <= '0;
            else if (w_pop && (pix_count_q != 16'hFFFF))
                pix_count_q <= pix_count_q + 16'd1;
        end
    end

    assign bus.pix_count = pix_count_q;
`else
    assign bus.pix_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tof_fb_write_arb.sv
// ============================================================================
// Module   : tb_tof_fb_write_arb
// Purpose  : Self-checking bench: vector table, corner sequences, random run
//            against a queue-based model of the write arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tof_fb_write_arb;
    import tof_fb_pkg::*;

    localparam int DEPTH = 16;

    logic clk_sys   = 1'b0;
    logic rst_sys_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    tof_fb_write_arb_if #(.ADDR_W(16), .FIFO_DEPTH(DEPTH)) bus ();

    tof_fb_write_arb #(.ADDR_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .bus       (bus)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];       // accepted pixels not yet written, {y,x}
    logic        m_ready     = 1'b0;
    logic        m_busy_prev = 1'b0;
    int          m_pix       = 0;
    int          plot_writes = 0;
    int          clear_writes = 0;

    typedef struct {
        logic       busy;
        logic       wen;
        logic [7:0] cx;
        logic [7:0] cy;
        logic       cd;
        logic       pv;
        logic [7:0] px;
        logic [7:0] py;
        logic       e_we;
        logic [15:0] e_addr;
        logic       e_din;
        logic       e_rdy;
        logic [4:0] e_lvl;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic set_in(input logic busy, input logic wen, input logic [7:0] cx,
                          input logic [7:0] cy, input logic cd, input logic pv,
                          input logic [7:0] px, input logic [7:0] py);
        bus.clr_busy    = busy;
        bus.clr_wr_en   = wen;
        bus.clr_wr_x    = cx;
        bus.clr_wr_y    = cy;
        bus.clr_wr_data = cd;
        bus.plot_valid  = pv;
        bus.plot_x      = px;
        bus.plot_y      = py;
    endtask

    task automatic set_idle();
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // One clock: inputs present now are sampled at the edge, outputs checked 1 later.
    task automatic cycle();
        logic        p_busy, p_wen, p_cd, p_acc, pw;
        logic [7:0]  p_cx, p_cy, p_px, p_py;
        logic [15:0] head;
        p_busy = bus.clr_busy;
        p_wen  = bus.clr_wr_en;
        p_cd   = bus.clr_wr_data;
        p_cx   = bus.clr_wr_x;
        p_cy   = bus.clr_wr_y;
        p_px   = bus.plot_x;
        p_py   = bus.plot_y;
        p_acc  = bus.plot_valid && m_ready && rst_sys_n;
        pw     = 1'b0;
        @(posedge clk_sys);
        #1;
        if (!rst_sys_n) begin
            exp_q.delete();
            m_ready     = 1'b0;
            m_busy_prev = 1'b0;
            m_pix       = 0;
            return;
        end
        if (p_acc) exp_q.push_back({p_py, p_px});
        if (p_wen) begin
            clear_writes++;
            check("clr_we",   bus.fb_we,   1);
            check("clr_addr", bus.fb_addr, {p_cy, p_cx});
            check("clr_din",  bus.fb_din,  p_cd);
        end else if (bus.fb_we !== 1'b0) begin
            check("plot_while_busy", p_busy, 0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_write: got addr %0h, expected no write at %0t",
                         bus.fb_addr, $time);
            end else begin
                head = exp_q.pop_front();
                plot_writes++;
                pw = 1'b1;
                check("plot_addr", bus.fb_addr, head);
                check("plot_din",  bus.fb_din,  1);
            end
        end
`ifdef TOF_FB_ARB_STATS_EN
        if (p_busy && !m_busy_prev) m_pix = 0;
        else if (pw && m_pix < 65535) m_pix++;
        m_busy_prev = p_busy;
        check("pix_count", bus.pix_count, m_pix);
`else
        check("pix_count", bus.pix_count, 0);
`endif
        check("level", bus.fifo_level, exp_q.size());
        m_ready = (exp_q.size() != DEPTH);
        check("ready", bus.plot_ready, m_ready);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        set_idle();
        while (exp_q.size() != 0 && n < 200) begin
            cycle();
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (3) cycle();
    endtask

    task automatic wait_plot(input string name);
        int n, base;
        n    = 0;
        base = plot_writes;
        while (plot_writes == base && n < 50) begin
            cycle();
            n++;
        end
        check(name, plot_writes, base + 1);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_p, base_c;
        set_idle();
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_we",    bus.fb_we,      0);
        check("rst_addr",  bus.fb_addr,    0);
        check("rst_din",   bus.fb_din,     0);
        check("rst_ready", bus.plot_ready, 0);
        check("rst_level", bus.fifo_level, 0);
        check("rst_pix",   bus.pix_count,  0);
        rst_sys_n = 1'b1;
        m_ready   = 1'b0;

        // busy wen cx cy cd pv px py | we addr din rdy lvl
        tbl[0]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 16'h0000, 0, 1, 5'd0};
        tbl[1]  = '{0, 0, 8'h00, 8'h00, 0, 1, 8'd3,  8'd5,  0, 16'h0000, 0, 1, 5'd1};
        tbl[2]  = '{0, 0, 8'h00, 8'h00, 0, 1, 8'd255, 8'd0, 0, 16'h0000, 0, 1, 5'd2};
        tbl[3]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 16'h0503, 1, 1, 5'd1};
        tbl[4]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 16'h00FF, 1, 1, 5'd0};
        tbl[5]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 16'h0000, 0, 1, 5'd0};
        tbl[6]  = '{1, 1, 8'h12, 8'h34, 0, 0, 8'h00, 8'h00, 1, 16'h3412, 0, 1, 5'd0};
        tbl[7]  = '{1, 1, 8'hAA, 8'h55, 1, 1, 8'd7,  8'd9,  1, 16'h55AA, 1, 1, 5'd1};
        tbl[8]  = '{1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 16'h0000, 0, 1, 5'd1};
        tbl[9]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 16'h0000, 0, 1, 5'd1};
        tbl[10] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 16'h0907, 1, 1, 5'd0};
        tbl[11] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 16'h0000, 0, 1, 5'd0};

        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].busy, tbl[i].wen, tbl[i].cx, tbl[i].cy, tbl[i].cd,
                   tbl[i].pv, tbl[i].px, tbl[i].py);
            cycle();
            check($sformatf("tbl%0d_we", i), bus.fb_we, tbl[i].e_we);
            if (tbl[i].e_we) begin
                check($sformatf("tbl%0d_addr", i), bus.fb_addr, tbl[i].e_addr);
                check($sformatf("tbl%0d_din", i),  bus.fb_din,  tbl[i].e_din);
            end
            check($sformatf("tbl%0d_rdy", i), bus.plot_ready, tbl[i].e_rdy);
            check($sformatf("tbl%0d_lvl", i), bus.fifo_level, tbl[i].e_lvl);
        end

        // Fill the FIFO while a clear is writing every cycle.
        base_p = plot_writes;
        base_c = clear_writes;
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 1'b1, 8'(i), 8'(i + 100), 1'(i), 1'b1,
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            cycle();
        end
        check("full_level", bus.fifo_level, 16);
        check("full_ready", bus.plot_ready, 0);
        check("full_noplot", plot_writes, base_p);
        drain("full_drain");
        check("full_plots", plot_writes, base_p + 16);
        check("full_clears", clear_writes, base_c + 20);

        // Clear arrives mid-drain with 8 queued.
        base_p = plot_writes;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'(i % 2), 8'(i), 8'h77, 1'b0, 1'b1, 8'(i * 3), 8'(i + 40));
            cycle();
        end
        set_idle();
        wait_plot("mid_first");
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 1'b1, 8'(i), 8'h88, 1'b1, 1'b0, 8'h00, 8'h00);
            cycle();
        end
        check("mid_hold", plot_writes, base_p + 1);
        drain("mid_drain");
        check("mid_total", plot_writes, base_p + 8);

        // Steady push+pop at level 5, long enough to wrap the pointers.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'(i), 8'hC0);
            cycle();
        end
        check("lvl4", bus.fifo_level, 4);
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h10, 8'hC1);
        wait_plot("lvl5_start");
        check("lvl5", bus.fifo_level, 5);
        for (int i = 0; i < 40; i++) begin
            set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'(i), 8'(i * 7));
            cycle();
            check("lvl5_hold", bus.fifo_level, 5);
        end
        drain("wrap_drain");

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'(i + 1), 8'h3C);
            cycle();
        end
        set_idle();
        wait_plot("arst_first");
        #2;
        rst_sys_n = 1'b0;
        #1;
        check("arst_we",    bus.fb_we,      0);
        check("arst_addr",  bus.fb_addr,    0);
        check("arst_din",   bus.fb_din,     0);
        check("arst_ready", bus.plot_ready, 0);
        check("arst_level", bus.fifo_level, 0);
        check("arst_pix",   bus.pix_count,  0);
        repeat (2) cycle();
        rst_sys_n = 1'b1;
        base_p = plot_writes;
        repeat (10) cycle();
        check("arst_nowrite", plot_writes, base_p);

        // Randomised traffic with clear bursts of random length.
        begin
            logic busy;
            busy = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if (busy) busy = ($urandom_range(0, 19) != 0);
                else      busy = ($urandom_range(0, 39) == 0);
                set_in(busy, busy & 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                cycle();
            end
        end
        drain("rand_drain");

`ifdef TOF_FB_ARB_STATS_EN
        set_in(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        cycle();
        check("stat_clr0", bus.pix_count, 0);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'(i), 8'h01);
            cycle();
        end
        drain("stat_drain");
        check("stat_three", bus.pix_count, 3);
        set_in(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        cycle();
        check("stat_clr", bus.pix_count, 0);
        for (int i = 0; i < 70010; i++) begin
            set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'(i), 8'(i >> 8));
            cycle();
        end
        drain("stat_sat_drain");
        check("stat_sat", bus.pix_count, 16'hFFFF);
`else
        check("stat_off", bus.pix_count, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tof_fb_write_arb.md
TOF_FB_WRITE_ARB -- requirements
Module: tof_fb_write_arb

Interface
REQ-001 Parameter: ADDR_W, default 16, framebuffer address width, {y[7:0],x[7:0]}.
REQ-002 Parameter: FIFO_DEPTH, default 16, plot-request FIFO entries, power of two, 4..64.
REQ-003 Port: clk_sys  input  1  system clock, all logic on rising edge.
REQ-004 Port: rst_sys_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: clr_busy  input  1  clear engine busy flag.
REQ-006 Port: clr_wr_en / clr_wr_x / clr_wr_y / clr_wr_data  input  1/8/8/1  clear-engine write request.
REQ-007 Port: plot_valid  input  1  plot pixel offered.
REQ-008 Port: plot_ready  output  1  plot pixel accepted when plot_valid & plot_ready.
REQ-009 Port: plot_x / plot_y  input  8/8  plot pixel coordinates.
REQ-010 Port: fb_we  output  1  framebuffer write strobe.
REQ-011 Port: fb_addr  output  ADDR_W  write address {y,x}.
REQ-012 Port: fb_din  output  1  write data.
REQ-013 Port: fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 Port: pix_count  output  16  plotted pixels since last clear start (macro-gated).

Function
REQ-015 Accepted plot pixels SHALL enter the FIFO; plot_ready SHALL equal !full, registered, independent of same-cycle pop.
REQ-016 FSM states S_IDLE, S_CLEAR, S_PLOT; S_IDLE -> S_CLEAR on clr_busy=1; S_IDLE -> S_PLOT on FIFO non-empty & clr_busy=0.
REQ-017 S_CLEAR: each clr_wr_en cycle SHALL produce fb_we=1, fb_addr={clr_wr_y,clr_wr_x}, fb_din=clr_wr_data one cycle later; FIFO SHALL NOT pop.
REQ-018 S_CLEAR -> S_PLOT when clr_busy=0 & clr_wr_en=0 & FIFO non-empty; else -> S_IDLE.
REQ-019 S_PLOT: pop one entry per cycle, fb_we=1, fb_addr={y,x}, fb_din=1, one-cycle latency from pop.
REQ-020 S_PLOT -> S_CLEAR immediately on clr_busy=1; the in-flight pop completes, no further pops.
REQ-021 S_PLOT -> S_IDLE when the last entry pops and clr_busy=0.
REQ-022 Clear SHALL have absolute priority; clr_wr_en is never stalled or dropped.
REQ-023 Pixels accepted during clear SHALL be retained and written after clear ends, in arrival order.
REQ-024 Simultaneous push and pop SHALL leave fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 Push when full SHALL be impossible (plot_ready=0); pop when empty SHALL NOT occur.
REQ-026 fb_we SHALL be 0 in S_IDLE and in any cycle without a clear write or pop.
REQ-027 At most one write per cycle; every output registered.

Reset
REQ-028 rst_sys_n=0 SHALL immediately force S_IDLE, empty FIFO, fb_we=0, fb_addr=0, fb_din=0, plot_ready=0, fifo_level=0, pix_count=0.
REQ-029 plot_ready SHALL rise on the first clock after rst_sys_n deasserts; FIFO contents are discarded on mid-operation reset.

Configuration
REQ-030 Macro TOF_FB_ARB_STATS_EN: defined -> pix_count increments per plot write, saturates at 16'hFFFF, clears on clr_busy rising edge.
REQ-031 Undefined -> pix_count tied to 0, counter logic absent.

Structure
REQ-032 Package tof_fb_pkg: FB_X_W=8, FB_Y_W=8, FB_ADDR_W=16, FSM state encoding, coordinate struct type.
REQ-033 FIFO SHALL be sub-module tof_sync_fifo (single clock, registered full/empty, level output).

Verification
REQ-034 Reset then push (3,5),(255,0) with clr_busy=0 -> fb_addr 16'h0503 then 16'h00FF, fb_din=1, one write each.
REQ-035 Fill FIFO (16 pushes) during clr_busy=1 -> plot_ready=0 at level 16; after clear ends, 16 writes in order, no clear write lost.
REQ-036 clr_busy rises mid-drain with 8 queued -> one in-flight write completes, then clear writes only; remaining 7 written after clear.
REQ-037 Simultaneous push and pop at level 5 -> fifo_level stays 5; pointer wrap after 40 pixels verified by data order.
REQ-038 rst_sys_n pulsed low asynchronously mid-drain -> outputs zero without a clock edge; no writes after release until new push.
REQ-039 With TOF_FB_ARB_STATS_EN: 3 plot writes -> pix_count=3; clr_busy rising -> 0; 70000 writes -> 16'hFFFF.
